fu_issue_arbiter: RTL and testbench

Per-cycle issue arbiter between the reservation station's ready candidates and the shared execution resources: the single-cycle ALU lanes, one pipelined multiplier with fixed latency `MULT_LAT`, and one non-pipelined memory port. It grants a candidate only when its functional unit is free and a CDB lane is guaranteed free at that candidate's writeback cycle. It tracks future CDB reservations in a shifting scoreboard, and rollback squashes all in-flight reservations. It sits between RS issue selection and the execute stage.

---
 rtl/fu_issue_arbiter.sv | 122 ++++++++++++
 tb/tb_fu_issue_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_arbiter.sv
// rtl/fu_issue_arbiter.sv - issue arbiter granting RS candidates against FU and CDB-lane availability
// Optional FU_ARB_AGE_PRIORITY_EN: age-ordered priority instead of index order.
module fu_issue_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CDB_WIDTH = 2,
    parameter int MULT_LAT  = 4,
    parameter int CNT_W     = 19
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  rollback_en,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0][1:0]               req_class,
    input  logic [NUM_REQ-1:0][CNT_W-1:0]         req_age,
    input  logic                                  mem_done,
    output logic [NUM_REQ-1:0]                    gnt,
    output logic [$clog2(NUM_REQ+1)-1:0]          gnt_cnt,
    output logic                                  mem_busy,
    output logic [$clog2(CDB_WIDTH+1)-1:0]        wb_free_next
);

    localparam int GW = $clog2(NUM_REQ+1);
    localparam int WW = $clog2(CDB_WIDTH+1);

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_MULT = 2'b01;
    localparam logic [1:0] CLS_MEM  = 2'b10;

    logic [WW-1:0]      wb_cnt [1:MULT_LAT];
    logic [NUM_REQ-1:0] ahead  [NUM_REQ];
    logic               mult_gnt;
    logic               mem_gnt;

    // ahead[i][j]: candidate j is visited before candidate i
`ifdef FU_ARB_AGE_PRIORITY_EN
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                ahead[i][j] = (j != i) &&
                              ((req_age[j] < req_age[i]) ||
                               ((req_age[j] == req_age[i]) && (j < i)));
            end
        end
    end
`else
    logic unused_age;
    assign unused_age = ^req_age;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                ahead[i][j] = (j < i);
            end
        end
    end
`endif

    // Classes never contend with each other, so each rule only needs the
    // count/presence of valid same-class candidates visited earlier.
    always_comb begin
        int  alu_before;
        int  alu_room;
        logic mult_before;
        logic mem_before;
        gnt         = '0;
        alu_before  = 0;
        mult_before = 1'b0;
        mem_before  = 1'b0;
        alu_room    = CDB_WIDTH - int'(wb_cnt[1]);
        for (int i = 0; i < NUM_REQ; i++) begin
            alu_before  = 0;
            mult_before = 1'b0;
            mem_before  = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (ahead[i][j] && req_valid[j]) begin
                    if (req_class[j] == CLS_ALU)  alu_before  = alu_before + 1;
                    if (req_class[j] == CLS_MULT) mult_before = 1'b1;
                    if (req_class[j] == CLS_MEM)  mem_before  = 1'b1;
                end
            end
            if (req_valid[i] && !reset && !rollback_en) begin
                case (req_class[i])
                    CLS_ALU:  gnt[i] = (alu_before < alu_room);
                    CLS_MULT: gnt[i] = !mult_before && (int'(wb_cnt[MULT_LAT]) < CDB_WIDTH);
                    CLS_MEM:  gnt[i] = !mem_before && !mem_busy;
                    default:  gnt[i] = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        gnt_cnt  = '0;
        mult_gnt = 1'b0;
        mem_gnt  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_cnt = gnt_cnt + {{(GW-1){1'b0}}, gnt[i]};
            if (gnt[i] && req_class[i] == CLS_MULT) mult_gnt = 1'b1;
            if (gnt[i] && req_class[i] == CLS_MEM)  mem_gnt  = 1'b1;
        end
    end

    assign wb_free_next = WW'(CDB_WIDTH) - wb_cnt[1];

    // A MULT granted now writes back at t+MULT_LAT, which is slot MULT_LAT-1
    // once the scoreboard has shifted by one.
    always_ff @(posedge clock) begin
        if (reset || rollback_en) begin
            for (int d = 1; d <= MULT_LAT; d++) wb_cnt[d] <= '0;
            mem_busy <= 1'b0;
        end else begin
            for (int d = 1; d < MULT_LAT; d++) wb_cnt[d] <= wb_cnt[d+1];
            wb_cnt[MULT_LAT] <= '0;
            if (mult_gnt) wb_cnt[MULT_LAT-1] <= wb_cnt[MULT_LAT] + WW'(1);
            if (mem_gnt)
                mem_busy <= 1'b1;
            else if (mem_done)
                mem_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb/tb_fu_issue_arbiter.sv - scoreboard bench for fu_issue_arbiter
module tb_fu_issue_arbiter;

    logic             clock;
    logic             reset;
    logic             rollback_en;
    logic [3:0]       req_valid;
    logic [3:0][1:0]  req_class;
    logic [3:0][18:0] req_age;
    logic             mem_done;
    logic [3:0]       gnt;
    logic [2:0]       gnt_cnt;
    logic             mem_busy;
    logic [1:0]       wb_free_next;

    fu_issue_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .rollback_en  (rollback_en),
        .req_valid    (req_valid),
        .req_class    (req_class),
        .req_age      (req_age),
        .mem_done     (mem_done),
        .gnt          (gnt),
        .gnt_cnt      (gnt_cnt),
        .mem_busy     (mem_busy),
        .wb_free_next (wb_free_next)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         id;
        logic [3:0] g;
        logic [2:0] n;
        logic       mb;
        logic [1:0] f;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

`ifdef FU_ARB_AGE_PRIORITY_EN
    localparam logic [3:0] EXP_AGE4  = 4'b1010;
    localparam logic [3:0] EXP_MULT1 = 4'b0100;
`else
    localparam logic [3:0] EXP_AGE4  = 4'b0011;
    localparam logic [3:0] EXP_MULT1 = 4'b0001;
`endif

    // class fields listed {req3, req2, req1, req0}: 00 ALU, 01 MULT, 10 MEM, 11 reserved
    localparam logic [7:0] C_ALL_ALU  = 8'b00_00_00_00;
    localparam logic [7:0] C_MULT0    = 8'b00_00_00_01;
    localparam logic [7:0] C_MULT02   = 8'b00_01_00_01;
    localparam logic [7:0] C_MEM1     = 8'b00_00_10_00;
    localparam logic [7:0] C_MULT_MEM = 8'b00_00_10_01;
    localparam logic [7:0] C_RSV      = 8'b11_11_11_11;

    task automatic step(input logic [3:0] v, input logic [7:0] c, input logic md,
                        input logic rb, input logic [3:0] eg, input logic emb,
                        input logic [1:0] ef);
        exp_t e;
        req_valid   = v;
        req_class   = c;
        mem_done    = md;
        rollback_en = rb;
        e.id = step_id;
        e.g  = eg;
        e.n  = 3'($countones(eg));
        e.mb = emb;
        e.f  = ef;
        q.push_back(e);
        step_id++;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (gnt !== e.g) begin
                errors++;
                $display("FAIL step %0d gnt: got %b expected %b", e.id, gnt, e.g);
            end
            checks++;
            if (gnt_cnt !== e.n) begin
                errors++;
                $display("FAIL step %0d gnt_cnt: got %0d expected %0d", e.id, gnt_cnt, e.n);
            end
            checks++;
            if (mem_busy !== e.mb) begin
                errors++;
                $display("FAIL step %0d mem_busy: got %b expected %b", e.id, mem_busy, e.mb);
            end
            checks++;
            if (wb_free_next !== e.f) begin
                errors++;
                $display("FAIL step %0d wb_free_next: got %0d expected %0d", e.id, wb_free_next, e.f);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        rollback_en = 1'b0;
        req_valid   = '0;
        req_class   = '0;
        req_age     = '0;
        mem_done    = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;

        // grants suppressed while reset is held
        step(4'b1111, C_ALL_ALU, 0, 0, 4'b0000, 0, 2'd2);
        reset = 1'b0;

        // four ALU candidates, two CDB lanes
        req_age[0] = 19'd7; req_age[1] = 19'd3; req_age[2] = 19'd9; req_age[3] = 19'd5;
        step(4'b1111, C_ALL_ALU, 0, 0, EXP_AGE4, 0, 2'd2);
        req_age = '0;

        // MULT reservation steals one ALU lane three cycles later
        step(4'b0001, C_MULT0,   0, 0, 4'b0001, 0, 2'd2);
        step(4'b0011, C_ALL_ALU, 0, 0, 4'b0011, 0, 2'd2);
        step(4'b0011, C_ALL_ALU, 0, 0, 4'b0011, 0, 2'd2);
        step(4'b0011, C_ALL_ALU, 0, 0, 4'b0001, 0, 2'd1);
        step(4'b0011, C_ALL_ALU, 0, 0, 4'b0011, 0, 2'd2);

        // two MULTs in one cycle: one now, the other next cycle
        req_age[0] = 19'd5; req_age[2] = 19'd2;
        step(4'b0101, C_MULT02, 0, 0, EXP_MULT1, 0, 2'd2);
        step(4'b0101 & ~EXP_MULT1, C_MULT02, 0, 0, 4'b0101 & ~EXP_MULT1, 0, 2'd2);
        req_age = '0;
        step(4'b0000, C_ALL_ALU, 0, 0, 4'b0000, 0, 2'd2);
        step(4'b0000, C_ALL_ALU, 0, 0, 4'b0000, 0, 2'd1);
        step(4'b0000, C_ALL_ALU, 0, 0, 4'b0000, 0, 2'd1);
        step(4'b0000, C_ALL_ALU, 0, 0, 4'b0000, 0, 2'd2);

        // memory port: single op in flight, freed by mem_done
        step(4'b0010, C_MEM1, 0, 0, 4'b0010, 0, 2'd2);
        for (int k = 0; k < 4; k++) step(4'b0010, C_MEM1, 0, 0, 4'b0000, 1, 2'd2);
        step(4'b0010, C_MEM1, 1, 0, 4'b0000, 1, 2'd2);
        step(4'b0010, C_MEM1, 0, 0, 4'b0010, 0, 2'd2);
        step(4'b0000, C_MEM1, 1, 0, 4'b0000, 1, 2'd2);
        step(4'b0000, C_MEM1, 1, 0, 4'b0000, 0, 2'd2);
        step(4'b0000, C_MEM1, 0, 0, 4'b0000, 0, 2'd2);

        // rollback squashes MULT reservation and memory busy
        step(4'b0011, C_MULT_MEM, 0, 0, 4'b0011, 0, 2'd2);
        step(4'b1111, C_ALL_ALU,  0, 1, 4'b0000, 1, 2'd2);
        step(4'b0010, C_MULT_MEM, 0, 0, 4'b0010, 0, 2'd2);
        step(4'b0000, C_ALL_ALU,  0, 0, 4'b0000, 1, 2'd2);
        step(4'b0000, C_ALL_ALU,  1, 0, 4'b0000, 1, 2'd2);
        step(4'b0000, C_ALL_ALU,  0, 0, 4'b0000, 0, 2'd2);

        // reserved class is never granted and leaves state alone
        step(4'b1111, C_RSV, 0, 0, 4'b0000, 0, 2'd2);
        step(4'b1111, C_RSV, 0, 0, 4'b0000, 0, 2'd2);
        step(4'b0000, C_RSV, 0, 0, 4'b0000, 0, 2'd2);

        // reset mid-operation discards reservations
        step(4'b0011, C_MULT_MEM, 0, 0, 4'b0011, 0, 2'd2);
        reset = 1'b1;
        step(4'b1111, C_ALL_ALU,  0, 0, 4'b0000, 1, 2'd2);
        reset = 1'b0;
        step(4'b0000, C_ALL_ALU,  0, 0, 4'b0000, 0, 2'd2);
        step(4'b0011, C_ALL_ALU,  0, 0, 4'b0011, 0, 2'd2);
        step(4'b0000, C_ALL_ALU,  0, 0, 4'b0000, 0, 2'd2);

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
